// File: rtl/mem_access_pkg.sv
// Shared opcodes, FSM states and access-size decode for the memory access sequencer.
package mem_access_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [2:0] {ST_IDLE, ST_READ, ST_CAPT, ST_WRITE, ST_RESP} state_t;

  typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2} acc_size_t;

  typedef struct packed {
    logic      legal;
    logic      store;
    logic      sgn;
    acc_size_t size;
  } dec_t;

  function automatic dec_t decode_op(input logic [5:0] op);
    dec_t d;
    d = '{legal: 1'b1, store: 1'b0, sgn: 1'b0, size: SZ_WORD};
    case (op)
      OP_LB:   begin d.size = SZ_BYTE; d.sgn = 1'b1; end
      OP_LBU:  d.size = SZ_BYTE;
      OP_LH:   begin d.size = SZ_HALF; d.sgn = 1'b1; end
      OP_LHU:  d.size = SZ_HALF;
      OP_LW:   d.size = SZ_WORD;
      OP_SB:   begin d.size = SZ_BYTE; d.store = 1'b1; end
      OP_SH:   begin d.size = SZ_HALF; d.store = 1'b1; end
      OP_SW:   begin d.size = SZ_WORD; d.store = 1'b1; end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Little-endian lane insert (store merge) and lane select (load extract, zero-filled).
// Latency: combinational. Backpressure: none.
// Sign extension of the selected lane is left to the caller.
module store_lane_merge
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [15:0] rt,
  input  acc_size_t   size,
  input  logic [1:0]  lane,
  output logic [31:0] merged,
  output logic [31:0] lane_dat
);

  always_comb begin
    merged   = word;
    lane_dat = word;
    case (size)
      SZ_BYTE: begin
        merged[{lane, 3'b000} +: 8] = rt[7:0];
        lane_dat = {24'd0, word[{lane, 3'b000} +: 8]};
      end
      SZ_HALF: begin
        merged[{lane[1], 4'b0000} +: 16] = rt;
        lane_dat = {16'd0, word[{lane[1], 4'b0000} +: 16]};
      end
      default: begin
        merged   = word;
        lane_dat = word;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_seq.sv
// Load/store sequencer between execute and a word-wide data memory; SB/SH run as read-merge-write.
// Latency accept->resp_valid: error 1, SW 2, loads 3, SB/SH 4 cycles.
// Backpressure: req_ready only in IDLE; one request in flight, upstream holds the next.
module mem_access_seq
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_opcode,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  state_t      state, state_nxt;
  acc_size_t   size_q;
  logic        store_q, sgn_q, err_q;
  logic [1:0]  lane_q;
  logic [15:0] rt_q;
  logic [31:0] data_q;
  dec_t        req_dec;
  logic        req_err, accept;
  logic [31:0] merged, lane_dat, load_res;

  assign req_dec = decode_op(req_opcode);
  assign req_err = !req_dec.legal
                || (req_dec.size == SZ_WORD && req_addr[1:0] != 2'b00)
                || (req_dec.size == SZ_HALF && req_addr[0]);
  assign accept  = req_valid && (state == ST_IDLE);

  store_lane_merge u_merge (
    .word     (mem_rdata),
    .rt       (rt_q),
    .size     (size_q),
    .lane     (lane_q),
    .merged   (merged),
    .lane_dat (lane_dat)
  );

  always_comb begin
    load_res = lane_dat;
    if (sgn_q) begin
      case (size_q)
        SZ_BYTE: load_res = {{24{lane_dat[7]}}, lane_dat[7:0]};
        SZ_HALF: load_res = {{16{lane_dat[15]}}, lane_dat[15:0]};
        default: load_res = lane_dat;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_err)                                     state_nxt = ST_RESP;
          else if (req_dec.store && req_dec.size == SZ_WORD) state_nxt = ST_WRITE;
          else                                             state_nxt = ST_READ;
        end
      end
      ST_READ:  state_nxt = ST_CAPT;
      ST_CAPT:  state_nxt = store_q ? ST_WRITE : ST_RESP;
      ST_WRITE: state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // data_q holds the SW word, the merged word for SB/SH, or the extracted load result.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      size_q   <= SZ_WORD;
      store_q  <= 1'b0;
      sgn_q    <= 1'b0;
      err_q    <= 1'b0;
      lane_q   <= 2'b00;
      rt_q     <= 16'd0;
      data_q   <= 32'd0;
      mem_addr <= '0;
    end else if (accept) begin
      size_q   <= req_dec.size;
      store_q  <= req_dec.store;
      sgn_q    <= req_dec.sgn;
      err_q    <= req_err;
      lane_q   <= req_addr[1:0];
      rt_q     <= req_wdata[15:0];
      data_q   <= (!req_err && req_dec.store && req_dec.size == SZ_WORD) ? req_wdata : 32'd0;
      mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
    end else if (state == ST_CAPT) begin
      data_q   <= store_q ? merged : load_res;
    end
  end

  assign req_ready  = (state == ST_IDLE);
  assign mem_rd_en  = (state == ST_READ);
  assign mem_wr_en  = (state == ST_WRITE);
  assign mem_wdata  = (state == ST_WRITE) ? data_q : 32'd0;
  assign resp_valid = (state == ST_RESP);
  assign resp_err   = (state == ST_RESP) && err_q;
  assign resp_rdata = (state == ST_RESP && !err_q && !store_q) ? data_q : 32'd0;

endmodule
